memblk_rdreq_sched: RTL and testbench
=====================================

// Module: memblk_rdreq_sched
// PURPOSE
//  Read-request scheduler directly upstream of memblk read ports. Collects 64-byte line reads
//  from NREQ requesters into per-requester FIFOs, round-robin packs up to NPORT grants per cycle
//  onto memblk rdaddr0/rden_in, tags each issue with requester id, and limits outstanding reads
//  with a credit counter refilled by memblk rden_out returns.
// PARAMETERS
//  NREQ     8   number of requesters
//  NPORT    5   memblk read ports driven
//  AW       27  line address width (memblk rdaddr0 element width)
//  QDEPTH   4   per-requester FIFO depth (power of 2, >=2)
//  CREDITS  16  max outstanding issued-but-unreturned reads
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  req_vld    in   NREQ         requester i presents a read
//  req_addr   in   NREQ*AW      line address per requester
//  req_rdy    out  NREQ         FIFO i can accept (count_i < QDEPTH)
//  mem_stall  in   1            block all issue this cycle
//  rdaddr0    out  NPORT*AW     to memblk rdaddr0
//  rden_in    out  NPORT        to memblk rden_in
//  rd_id      out  NPORT*3      requester id of each issued port (log2 NREQ bits)
//  ret_vld    in   NPORT        returns completed (connect memblk rden_out)
//  credits    out  5            current free credits (log2(CREDITS)+1 bits)
//  err_credit out  1            sticky: return with credits already == CREDITS
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): all FIFOs empty, rr_ptr=0, credits=CREDITS, rden_in=0,
//   rdaddr0=0, rd_id=0, err_credit=0; req_rdy=all-ones from the cycle after reset. Reset mid-
//   traffic drops queued and in-flight bookkeeping; returns arriving after reset are ignored
//   for err_credit only in the first cycle after reset deasserts.
//  Enqueue: push when req_vld[i]&req_rdy[i]. req_rdy combinational from registered count only
//   (no dependence on same-cycle pop). Push+pop same cycle allowed; count unchanged.
//   No bypass: entry pushed in cycle t is eligible for grant at earliest cycle t+1.
//  Arbitration (combinational on registered state, each cycle):
//   limit = mem_stall ? 0 : min(NPORT, credits).
//   Scan requesters rr_ptr, rr_ptr+1, ... mod NREQ; each non-empty FIFO gets at most one grant
//   per cycle; stop at limit grants or after NREQ examined.
//   k-th grant (k=0..) goes to port k; ports >= grant count get rden_in=0 (rdaddr0 holds value).
//   Granted FIFOs pop their head.
//   rr_ptr <= (last granted index + 1) mod NREQ if any grant, else unchanged.
//  Issue latency: grant in cycle t -> rden_in/rdaddr0/rd_id registered, valid in cycle t+1.
//   rden_in is a 1-cycle pulse per issue; no backpressure from memblk beyond mem_stall.
//  Credits: credits <= credits - grants + popcount(ret_vld), computed same cycle.
//   grants never exceed credits, so credits never negative. If credits - grants + returns
//   would exceed CREDITS: clamp at CREDITS, set err_credit (sticky until rst).
//   Returns in cycle t are usable for grants from cycle t+1 (no same-cycle credit bypass).
//  Full/empty: FIFO full -> req_rdy[i]=0, req_vld ignored (requester must hold). All FIFOs
//   empty -> no grants, rr_ptr unchanged. credits==0 -> no grants, FIFOs hold, rr_ptr unchanged.
//  Ordering: per-requester issue order equals push order; no ordering across requesters.
// TESTING
//  1 Reset: rst=1 two cycles -> rden_in=0, credits=16, req_rdy=8'hFF, err_credit=0 after release.
//  2 Single req: req_vld[3]=1 addr=27'h12345 at t -> rden_in=5'b00001, rdaddr0[0]=27'h12345,
//    rd_id[0]=3 at t+2; credits=15 at t+2.
//  3 Fairness: all 8 FIFOs hold 4 entries, rr_ptr=0, ret_vld=1:1 loopback -> cycle1 grants req0-4
//    on ports0-4, cycle2 req5,6,7,0,1; every requester served 5 times per 8 cycles.
//  4 Credit limit: no returns, 8 requesters saturating -> exactly 16 issues total, then rden_in=0,
//    credits=0; drive ret_vld=5'b00111 -> next cycle 3 grants issue.
//  5 FIFO full/stall: mem_stall=1, req_vld[2] held 6 cycles -> req_rdy[2]=0 after 4 pushes;
//    drop stall -> 4 entries issue in push order, one per cycle.
//  6 Error: credits=16, ret_vld=5'b00001 -> credits stays 16, err_credit=1 until rst.

Source files
------------

// File: rtl/memblk_rdreq_sched.sv
// Read-request scheduler feeding memblk read ports: per-requester FIFOs, round-robin packing of
// up to NPORT grants per cycle, and credit-limited outstanding reads refilled by returns.
module memblk_rdreq_sched #(
    parameter int unsigned NREQ    = 8,
    parameter int unsigned NPORT   = 5,
    parameter int unsigned AW      = 27,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned CREDITS = 16,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned CW     = $clog2(CREDITS) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_vld_i,
    input  logic [NREQ*AW-1:0]    req_addr_i,
    output logic [NREQ-1:0]       req_rdy_o,
    input  logic                  mem_stall_i,
    output logic [NPORT*AW-1:0]   rdaddr0_o,
    output logic [NPORT-1:0]      rden_in_o,
    output logic [NPORT*IDW-1:0]  rd_id_o,
    input  logic [NPORT-1:0]      ret_vld_i,
    output logic [CW-1:0]         credits_o,
    output logic                  err_credit_o
);
    localparam int unsigned PW   = $clog2(QDEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [AW-1:0]    mem_q    [NREQ][QDEPTH];
    logic [PW-1:0]    wptr_q   [NREQ];
    logic [PW-1:0]    rptr_q   [NREQ];
    logic [CNTW-1:0]  cnt_q    [NREQ];
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             err_q, err_d;
    logic             just_rst_q;
    logic [NPORT-1:0] rden_q, rden_d;
    logic [AW-1:0]    addr_q   [NPORT];
    logic [AW-1:0]    addr_d   [NPORT];
    logic [IDW-1:0]   id_q     [NPORT];
    logic [IDW-1:0]   id_d     [NPORT];
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   idx, last_idx;
    int               limit, n_grant, ret_cnt, cred_sum;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_rdy_o[i] = cnt_q[i] < CNTW'(QDEPTH);
            push[i]      = req_vld_i[i] & req_rdy_o[i];
        end
    end

    always_comb begin
        grant    = '0;
        rden_d   = '0;
        n_grant  = 0;
        idx      = '0;
        last_idx = rr_ptr_q;
        for (int p = 0; p < int'(NPORT); p++) begin
            addr_d[p] = addr_q[p];
            id_d[p]   = id_q[p];
        end
        limit = mem_stall_i ? 0 :
                ((int'(credits_q) < int'(NPORT)) ? int'(credits_q) : int'(NPORT));
        // k-th granted requester in scan order lands on port k
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = IDW'((int'(rr_ptr_q) + i) % int'(NREQ));
            if ((cnt_q[idx] != '0) && (n_grant < limit)) begin
                grant[idx]      = 1'b1;
                rden_d[n_grant] = 1'b1;
                addr_d[n_grant] = mem_q[idx][rptr_q[idx]];
                id_d[n_grant]   = idx;
                last_idx        = idx;
                n_grant         = n_grant + 1;
            end
        end
        rr_ptr_d = (n_grant != 0) ? IDW'((int'(last_idx) + 1) % int'(NREQ)) : rr_ptr_q;

        ret_cnt  = $countones(ret_vld_i);
        cred_sum = int'(credits_q) - n_grant + ret_cnt;
        err_d    = err_q;
        if (cred_sum > int'(CREDITS)) begin
            credits_d = CW'(CREDITS);
            // Stray returns right after reset belong to traffic that reset discarded
            if (!just_rst_q) begin
                err_d = 1'b1;
            end
        end else begin
            credits_d = CW'(cred_sum);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            for (int p = 0; p < int'(NPORT); p++) begin
                addr_q[p] <= '0;
                id_q[p]   <= '0;
            end
            rr_ptr_q   <= '0;
            credits_q  <= CW'(CREDITS);
            err_q      <= 1'b0;
            just_rst_q <= 1'b1;
            rden_q     <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + 1'b1;
                end
                if (grant[i]) begin
                    rptr_q[i] <= rptr_q[i] + 1'b1;
                end
                cnt_q[i] <= cnt_q[i] + CNTW'(push[i]) - CNTW'(grant[i]);
            end
            for (int p = 0; p < int'(NPORT); p++) begin
                addr_q[p] <= addr_d[p];
                id_q[p]   <= id_d[p];
            end
            rr_ptr_q   <= rr_ptr_d;
            credits_q  <= credits_d;
            err_q      <= err_d;
            just_rst_q <= 1'b0;
            rden_q     <= rden_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NREQ); i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= req_addr_i[i*AW +: AW];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < int'(NPORT); p++) begin
            rdaddr0_o[p*AW +: AW]  = addr_q[p];
            rd_id_o[p*IDW +: IDW]  = id_q[p];
        end
    end

    assign rden_in_o    = rden_q;
    assign credits_o    = credits_q;
    assign err_credit_o = err_q;

endmodule

// File: tb/tb_memblk_rdreq_sched.sv
// Directed bench for memblk_rdreq_sched: reset, single issue, round-robin fairness,
// credit exhaustion/refill, FIFO full under stall, and sticky credit error.
module tb_memblk_rdreq_sched;
    localparam int AW = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    req_vld;
    logic [8*AW-1:0] req_addr;
    logic [7:0]    req_rdy;
    logic          mem_stall;
    logic [5*AW-1:0] rdaddr0;
    logic [4:0]    rden_in;
    logic [14:0]   rd_id;
    logic [4:0]    ret_vld;
    logic [4:0]    ret_drv;
    logic          loop_en;
    logic [4:0]    credits;
    logic          err_credit;

    int checks = 0;
    int errors = 0;

    assign ret_vld = loop_en ? rden_in : ret_drv;

    always #5 clk = ~clk;

    memblk_rdreq_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_vld_i    (req_vld),
        .req_addr_i   (req_addr),
        .req_rdy_o    (req_rdy),
        .mem_stall_i  (mem_stall),
        .rdaddr0_o    (rdaddr0),
        .rden_in_o    (rden_in),
        .rd_id_o      (rd_id),
        .ret_vld_i    (ret_vld),
        .credits_o    (credits),
        .err_credit_o (err_credit)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release
    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        mem_stall = 1'b0;
        ret_drv = '0;
        loop_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_addr = '0;
        do_reset();
        checks++;
        if (rden_in !== 5'b0) begin
            errors++; $display("FAIL reset_rden got %b want 00000", rden_in);
        end
        checks++;
        if (credits !== 5'd16) begin
            errors++; $display("FAIL reset_credits got %0d want 16", credits);
        end
        checks++;
        if (req_rdy !== 8'hFF) begin
            errors++; $display("FAIL reset_rdy got %h want ff", req_rdy);
        end
        checks++;
        if (err_credit !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b want 0", err_credit);
        end
        checks++;
        if (rdaddr0 !== '0 || rd_id !== '0) begin
            errors++; $display("FAIL reset_outs got addr %h id %h want 0", rdaddr0, rd_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        step();
        req_vld = 8'h08;
        req_addr[3*AW +: AW] = 27'h12345;
        step();
        req_vld = '0;
        step();
        checks++;
        if (rden_in !== 5'b00001) begin
            errors++; $display("FAIL single_rden got %b want 00001", rden_in);
        end
        checks++;
        if (rdaddr0[AW-1:0] !== 27'h12345) begin
            errors++; $display("FAIL single_addr got %h want 12345", rdaddr0[AW-1:0]);
        end
        checks++;
        if (rd_id[2:0] !== 3'd3) begin
            errors++; $display("FAIL single_id got %0d want 3", rd_id[2:0]);
        end
        checks++;
        if (credits !== 5'd15) begin
            errors++; $display("FAIL single_credits got %0d want 15", credits);
        end
        step();
        checks++;
        if (rden_in !== 5'b0 || credits !== 5'd15) begin
            errors++; $display("FAIL single_pulse got rden %b cr %0d want 00000 15", rden_in, credits);
        end
        ret_drv = 5'b00001;
        step();
        ret_drv = '0;
        checks++;
        if (credits !== 5'd16 || err_credit !== 1'b0) begin
            errors++; $display("FAIL single_return got cr %0d err %b want 16 0", credits, err_credit);
        end
    endtask

    task automatic test_fairness();
        int served [8];
        int id;
        logic [AW-1:0] exp_addr;
        for (int r = 0; r < 8; r++) served[r] = 0;
        do_reset();
        step();
        mem_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 8; r++) req_addr[r*AW +: AW] = 27'((r << 8) | k);
            req_vld = 8'hFF;
            step();
        end
        for (int r = 0; r < 8; r++) req_addr[r*AW +: AW] = 27'((r << 8) | 8'hAA);
        mem_stall = 1'b0;
        loop_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (rden_in !== 5'b11111 || credits !== 5'd11) begin
                errors++;
                $display("FAIL fair_cycle%0d got rden %b cr %0d want 11111 11", c, rden_in, credits);
            end
            for (int p = 0; p < 5; p++) begin
                id = (c * 5 + p) % 8;
                exp_addr = (served[id] < 4) ? 27'((id << 8) | served[id]) : 27'((id << 8) | 8'hAA);
                checks++;
                if (rd_id[p*3 +: 3] !== 3'(id) || rdaddr0[p*AW +: AW] !== exp_addr) begin
                    errors++;
                    $display("FAIL fair_c%0d_p%0d got id %0d addr %h want id %0d addr %h",
                             c, p, rd_id[p*3 +: 3], rdaddr0[p*AW +: AW], id, exp_addr);
                end
                served[int'(rd_id[p*3 +: 3])]++;
            end
        end
        req_vld = '0;
        loop_en = 1'b0;
        mem_stall = 1'b1;
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (served[r] !== 5) begin
                errors++; $display("FAIL fair_count_req%0d got %0d want 5", r, served[r]);
            end
        end
    endtask

    task automatic test_credit_limit();
        int total = 0;
        do_reset();
        step();
        for (int r = 0; r < 8; r++) req_addr[r*AW +: AW] = 27'(r);
        req_vld = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            step();
            total += $countones(rden_in);
        end
        checks++;
        if (total !== 16) begin
            errors++; $display("FAIL credit_total got %0d want 16", total);
        end
        checks++;
        if (rden_in !== 5'b0 || credits !== 5'd0) begin
            errors++; $display("FAIL credit_empty got rden %b cr %0d want 00000 0", rden_in, credits);
        end
        ret_drv = 5'b00111;
        step();
        ret_drv = '0;
        checks++;
        if (rden_in !== 5'b0 || credits !== 5'd3) begin
            errors++; $display("FAIL credit_refill got rden %b cr %0d want 00000 3", rden_in, credits);
        end
        step();
        checks++;
        if (rden_in !== 5'b00111 || credits !== 5'd0) begin
            errors++; $display("FAIL credit_reissue got rden %b cr %0d want 00111 0", rden_in, credits);
        end
        req_vld = '0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        step();
        mem_stall = 1'b1;
        req_vld = 8'h04;
        for (int k = 0; k < 6; k++) begin
            req_addr[2*AW +: AW] = 27'(27'h100 + k);
            step();
            checks++;
            if (req_rdy[2] !== (k < 3) || rden_in !== 5'b0) begin
                errors++;
                $display("FAIL full_push%0d got rdy %b rden %b want %b 00000", k, req_rdy[2], rden_in, k < 3);
            end
        end
        req_vld = '0;
        mem_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (rden_in !== 5'b00001 || rdaddr0[AW-1:0] !== 27'(27'h100 + k) || rd_id[2:0] !== 3'd2) begin
                errors++;
                $display("FAIL full_drain%0d got rden %b addr %h id %0d want 00001 %h 2",
                         k, rden_in, rdaddr0[AW-1:0], rd_id[2:0], 27'(27'h100 + k));
            end
            checks++;
            if (req_rdy[2] !== 1'b1) begin
                errors++; $display("FAIL full_rdy_back%0d got %b want 1", k, req_rdy[2]);
            end
        end
        step();
        checks++;
        if (rden_in !== 5'b0) begin
            errors++; $display("FAIL full_done got rden %b want 00000", rden_in);
        end
    endtask

    task automatic test_error();
        // A return in the first cycle after reset is excused
        do_reset();
        ret_drv = 5'b00001;
        step();
        ret_drv = '0;
        checks++;
        if (err_credit !== 1'b0 || credits !== 5'd16) begin
            errors++; $display("FAIL err_grace got err %b cr %0d want 0 16", err_credit, credits);
        end
        ret_drv = 5'b00001;
        step();
        ret_drv = '0;
        checks++;
        if (err_credit !== 1'b1 || credits !== 5'd16) begin
            errors++; $display("FAIL err_set got err %b cr %0d want 1 16", err_credit, credits);
        end
        step();
        step();
        checks++;
        if (err_credit !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b want 1", err_credit);
        end
        do_reset();
        checks++;
        if (err_credit !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b want 0", err_credit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_vld = '0;
        req_addr = '0;
        mem_stall = 1'b0;
        ret_drv = '0;
        loop_en = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_credit_limit();
        test_fifo_full();
        test_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
